// File: rtl/darkroom_spi_rx.sv
// darkroom_spi_rx: SPI slave receiver (mode 0, MSB first) for the darkroom
// sensor link. SCK, SS_N and MOSI are oversampled on the local clock. Received
// WORD_WIDTH-bit words are queued in a show-ahead FIFO. The FIFO drives a
// valid/ready stream to the host side.
//
// Optional build macro: DARKROOM_SPI_RX_ECHO_EN
//   When defined, spi_miso_o shifts out the previously completed word for
//   loopback. When undefined, spi_miso_o is tied low.
//
// Ports:
//   clk, reset_n   system clock, asynchronous active-low reset
//   spi_sck_i      SPI clock (async, at most clk/8)
//   spi_mosi_i     SPI data in (async)
//   spi_ss_n_i     slave select, active low (async)
//   spi_miso_o     echo data, or 0 when echo is disabled
//   rx_data_o      head-of-FIFO word
//   rx_first_o     head word was the first word of its frame
//   rx_valid_o     FIFO not empty
//   rx_ready_i     consumer accepts the head word
//   fifo_level_o   registered FIFO occupancy, 0..FIFO_DEPTH
//   overflow_o     sticky: a word was dropped because the FIFO was full
//   frag_cnt_o     saturating count of discarded partial words
//   clear_i        synchronous clear of overflow_o and frag_cnt_o
module darkroom_spi_rx #(
  parameter int WORD_WIDTH = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          spi_sck_i,
  input  logic                          spi_mosi_i,
  input  logic                          spi_ss_n_i,
  output logic                          spi_miso_o,
  output logic [WORD_WIDTH-1:0]         rx_data_o,
  output logic                          rx_first_o,
  output logic                          rx_valid_o,
  input  logic                          rx_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          overflow_o,
  output logic [CNT_WIDTH-1:0]          frag_cnt_o,
  input  logic                          clear_i
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int BCW = $clog2(WORD_WIDTH);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(WORD_WIDTH - 1);
  localparam logic [AW:0]    FULL_LVL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  // Input synchronisers plus one edge-detect stage for SCK and SS_N
  logic sck_s1, sck_s2, sck_d;
  logic ss_s1, ss_s2, ss_d;
  logic mosi_s1, mosi_s2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sck_s1  <= 1'b0;
      sck_s2  <= 1'b0;
      sck_d   <= 1'b0;
      ss_s1   <= 1'b1;
      ss_s2   <= 1'b1;
      ss_d    <= 1'b1;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
    end else begin
      sck_s1  <= spi_sck_i;
      sck_s2  <= sck_s1;
      sck_d   <= sck_s2;
      ss_s1   <= spi_ss_n_i;
      ss_s2   <= ss_s1;
      ss_d    <= ss_s2;
      mosi_s1 <= spi_mosi_i;
      mosi_s2 <= mosi_s1;
    end
  end

  logic sck_rise, ss_fall, ss_rise;
  assign sck_rise = sck_s2 & ~sck_d;
  assign ss_fall  = ~ss_s2 & ss_d;
  assign ss_rise  = ss_s2 & ~ss_d;

  // Receive state machine
  state_t                state_q, state_d;
  logic [WORD_WIDTH-1:0] shift_q, shift_d;
  logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                  first_pend_q, first_pend_d;
  logic [WORD_WIDTH-1:0] done_word;
  logic                  word_done;
  logic                  frag_inc;

  assign done_word = {shift_q[WORD_WIDTH-2:0], mosi_s2};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      first_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      first_pend_q <= first_pend_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    first_pend_d = first_pend_q;
    word_done    = 1'b0;
    frag_inc     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ss_fall) begin
          state_d      = ST_SHIFT;
          bit_cnt_d    = '0;
          first_pend_d = 1'b1;
        end
      end
      ST_SHIFT: begin
        // An SS_N rise takes priority over a coincident SCK rise.
        if (ss_rise) begin
          state_d   = ST_IDLE;
          bit_cnt_d = '0;
          frag_inc  = (bit_cnt_q != '0);
        end else if (sck_rise && !ss_s2) begin
          shift_d = done_word;
          if (bit_cnt_q == LAST_BIT) begin
            // The push register samples first_pend_q in this same cycle, so
            // clearing it here equals clearing it after the push.
            word_done    = 1'b1;
            bit_cnt_d    = '0;
            first_pend_d = 1'b0;
          end else begin
            bit_cnt_d = bit_cnt_q + BCW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The completed word is presented to the FIFO one cycle after completion
  logic                  push_req_q;
  logic [WORD_WIDTH-1:0] push_data_q;
  logic                  push_first_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      push_req_q   <= 1'b0;
      push_data_q  <= '0;
      push_first_q <= 1'b0;
    end else begin
      push_req_q <= word_done;
      if (word_done) begin
        push_data_q  <= done_word;
        push_first_q <= first_pend_q;
      end
    end
  end

  // Show-ahead circular FIFO of {first, data}
  logic [WORD_WIDTH:0] mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [AW:0]         level_q;
  logic                full, pop, wr_en, drop;
  logic [WORD_WIDTH:0] head;

  assign full       = (level_q == FULL_LVL);
  assign rx_valid_o = (level_q != '0);
  assign pop        = rx_valid_o & rx_ready_i;
  // A pop in the same cycle frees a slot, so a push into a full FIFO succeeds.
  assign wr_en      = push_req_q & (~full | pop);
  assign drop       = push_req_q & full & ~pop;
  assign head       = mem[rd_ptr];
  assign rx_data_o  = rx_valid_o ? head[WORD_WIDTH-1:0] : '0;
  assign rx_first_o = rx_valid_o & head[WORD_WIDTH];
  assign fifo_level_o = level_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {push_first_q, push_data_q};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   level_q <= level_q + (AW + 1)'(1);
        2'b01:   level_q <= level_q - (AW + 1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Error status. An event coincident with clear_i survives the clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_o <= 1'b0;
      frag_cnt_o <= '0;
    end else begin
      if (clear_i)   overflow_o <= drop;
      else if (drop) overflow_o <= 1'b1;

      if (clear_i)
        frag_cnt_o <= CNT_WIDTH'(frag_inc);
      else if (frag_inc && (frag_cnt_o != '1))
        frag_cnt_o <= frag_cnt_o + CNT_WIDTH'(1);
    end
  end

`ifdef DARKROOM_SPI_RX_ECHO_EN
  // Loopback echo of the previous word. The SCK fall right after a completing
  // rise is skipped. This keeps the freshly loaded MSB on the line for the
  // next word's first rise. Each new frame restarts from the stored last word.
  logic                  sck_fall;
  logic [WORD_WIDTH-1:0] echo_word, echo_sr;
  logic                  echo_skip;

  assign sck_fall = ~sck_s2 & sck_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      echo_word <= '0;
      echo_sr   <= '0;
      echo_skip <= 1'b0;
    end else if (word_done) begin
      echo_word <= done_word;
      echo_sr   <= done_word;
      echo_skip <= 1'b1;
    end else if (ss_fall) begin
      echo_sr   <= echo_word;
      echo_skip <= 1'b0;
    end else if (sck_fall && !ss_s2) begin
      if (echo_skip) echo_skip <= 1'b0;
      else           echo_sr   <= {echo_sr[WORD_WIDTH-2:0], 1'b0};
    end
  end

  assign spi_miso_o = ~ss_s2 & echo_sr[WORD_WIDTH-1];
`else
  assign spi_miso_o = 1'b0;
`endif

endmodule

// File: tb/tb_darkroom_spi_rx.sv
// Testbench for darkroom_spi_rx. It drives mode-0 SPI frames at clk/8. A
// scoreboard queue holds the expected {first, data} entries, and a monitor
// pops and compares each word the DUT hands over.
module tb_darkroom_spi_rx;

  localparam int W     = 32;
  localparam int DEPTH = 16;
  localparam int CW    = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          spi_sck_i, spi_mosi_i, spi_ss_n_i;
  logic          spi_miso_o;
  logic [W-1:0]  rx_data_o;
  logic          rx_first_o, rx_valid_o, rx_ready_i;
  logic [4:0]    fifo_level_o;
  logic          overflow_o;
  logic [CW-1:0] frag_cnt_o;
  logic          clear_i;

  darkroom_spi_rx #(.WORD_WIDTH(W), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset_n(reset_n),
    .spi_sck_i(spi_sck_i), .spi_mosi_i(spi_mosi_i), .spi_ss_n_i(spi_ss_n_i),
    .spi_miso_o(spi_miso_o),
    .rx_data_o(rx_data_o), .rx_first_o(rx_first_o), .rx_valid_o(rx_valid_o),
    .rx_ready_i(rx_ready_i), .fifo_level_o(fifo_level_o),
    .overflow_o(overflow_o), .frag_cnt_o(frag_cnt_o), .clear_i(clear_i)
  );

  always #5 clk = ~clk;

  int unsigned   n_checks = 0;
  int unsigned   n_errors = 0;
  logic [W:0]    exp_q[$];
  logic          exp_first;
  int unsigned   last_lat;
  logic [W-1:0]  miso_cap;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: a transfer happens on the posedge after valid & ready are seen.
  always begin
    @(negedge clk);
    #1;
    if (reset_n && rx_valid_o && rx_ready_i) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_pop", 64'(rx_data_o), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        logic [W:0] e;
        e = exp_q.pop_front();
        check_val("pop_data", 64'(rx_data_o), 64'(e[W-1:0]));
        check_val("pop_first", 64'(rx_first_o), 64'(e[W]));
      end
    end
  end

  task automatic wait_neg(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic ss_low();
    spi_ss_n_i = 1'b0;
    exp_first  = 1'b1;
    wait_neg(8);
  endtask

  task automatic ss_high();
    spi_ss_n_i = 1'b1;
    wait_neg(8);
  endtask

  // Send nbits of w MSB first. A full word pushes its expected entry. The
  // entry is dropped if the model FIFO is full and no pop coincides. With
  // pop_on_last, rx_ready_i is pulsed so the pop lands in the push cycle.
  task automatic send_bits(input logic [W-1:0] w, input int unsigned nbits, input bit pop_on_last);
    miso_cap = '0;
    last_lat = 0;
    for (int unsigned b = 0; b < nbits; b++) begin
      spi_mosi_i = w[W-1-b];
      wait_neg(4);
      miso_cap = {miso_cap[W-2:0], spi_miso_o};
      spi_sck_i = 1'b1;
      if (b == W - 1) begin
        if (exp_q.size() < DEPTH || pop_on_last) exp_q.push_back({exp_first, w});
        exp_first = 1'b0;
        for (int unsigned k = 1; k <= 5; k++) begin
          @(negedge clk);
          if (pop_on_last && k == 3) rx_ready_i = 1'b1;
          if (pop_on_last && k == 4) rx_ready_i = 1'b0;
          if (rx_valid_o && last_lat == 0) last_lat = k;
        end
      end else begin
        wait_neg(4);
      end
      spi_sck_i = 1'b0;
    end
    wait_neg(4);
  endtask

  task automatic drain();
    rx_ready_i = 1'b1;
    for (int unsigned i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!rx_valid_o && exp_q.size() == 0) break;
    end
    rx_ready_i = 1'b0;
    check_val("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    check_val("drain_valid_low", 64'(rx_valid_o), 64'd0);
    check_val("drain_level_zero", 64'(fifo_level_o), 64'd0);
  endtask

  initial begin
    reset_n = 1'b0; spi_sck_i = 1'b0; spi_mosi_i = 1'b0; spi_ss_n_i = 1'b1;
    rx_ready_i = 1'b0; clear_i = 1'b0; exp_first = 1'b0;
    wait_neg(4);
    check_val("rst_valid", 64'(rx_valid_o), 64'd0);
    check_val("rst_data", 64'(rx_data_o), 64'd0);
    check_val("rst_level", 64'(fifo_level_o), 64'd0);
    reset_n = 1'b1;
    wait_neg(4);
    check_val("idle_overflow", 64'(overflow_o), 64'd0);
    check_val("idle_frag", 64'(frag_cnt_o), 64'd0);
    check_val("idle_miso", 64'(spi_miso_o), 64'd0);

    // Single word with latency check
    ss_low();
    send_bits(32'hDEADBEEF, W, 1'b0);
    check_val("single_latency_ok", 64'(last_lat >= 1 && last_lat <= 5), 64'd1);
    ss_high();
    check_val("single_level", 64'(fifo_level_o), 64'd1);
    check_val("single_frag", 64'(frag_cnt_o), 64'd0);
`ifndef DARKROOM_SPI_RX_ECHO_EN
    check_val("miso_tied_low", 64'(miso_cap), 64'd0);
`endif
    drain();

    // Multi-word frame, level steps with ready low
    ss_low();
    send_bits(32'h00000001, W, 1'b0);
    check_val("multi_level1", 64'(fifo_level_o), 64'd1);
    send_bits(32'h80000000, W, 1'b0);
    check_val("multi_level2", 64'(fifo_level_o), 64'd2);
    send_bits(32'hA5A5A5A5, W, 1'b0);
    check_val("multi_level3", 64'(fifo_level_o), 64'd3);
    ss_high();
    drain();

    // Fragment, then a clean frame
    ss_low();
    send_bits(32'hFFFFF000, 20, 1'b0);
    ss_high();
    check_val("frag_count", 64'(frag_cnt_o), 64'd1);
    check_val("frag_no_push", 64'(fifo_level_o), 64'd0);
    ss_low();
    send_bits(32'hCAFEF00D, W, 1'b0);
    ss_high();
    drain();

    // Overflow: 17 words into a 16-deep FIFO
    ss_low();
    for (int unsigned i = 1; i <= 17; i++) send_bits(32'h01010101 * i + 32'h10, W, 1'b0);
    ss_high();
    check_val("ovf_level", 64'(fifo_level_o), 64'd16);
    check_val("ovf_flag", 64'(overflow_o), 64'd1);
    @(negedge clk); clear_i = 1'b1;
    @(negedge clk); clear_i = 1'b0;
    check_val("ovf_cleared", 64'(overflow_o), 64'd0);
    check_val("frag_cleared", 64'(frag_cnt_o), 64'd0);
    check_val("clear_keeps_level", 64'(fifo_level_o), 64'd16);

    // Full FIFO with a pop in the push cycle
    ss_low();
    send_bits(32'h0F0F1234, W, 1'b1);
    check_val("fullpop_level", 64'(fifo_level_o), 64'd16);
    check_val("fullpop_ovf", 64'(overflow_o), 64'd0);
    ss_high();
    drain();

    // Reset mid-word
    ss_low();
    send_bits(32'hFFFFFFFF, 10, 1'b0);
    reset_n = 1'b0;
    wait_neg(2);
    check_val("midrst_frag", 64'(frag_cnt_o), 64'd0);
    check_val("midrst_valid", 64'(rx_valid_o), 64'd0);
    spi_ss_n_i = 1'b1; spi_sck_i = 1'b0;
    exp_q.delete();
    wait_neg(4);
    reset_n = 1'b1;
    wait_neg(8);
    ss_low();
    send_bits(32'h12345678, W, 1'b0);
    ss_high();
    check_val("midrst_one_entry", 64'(fifo_level_o), 64'd1);
    check_val("midrst_frag_after", 64'(frag_cnt_o), 64'd0);
`ifdef DARKROOM_SPI_RX_ECHO_EN
    check_val("echo_zero_after_reset", 64'(miso_cap), 64'd0);
`endif
    drain();
    ss_low();
    send_bits(32'h5A5A0FF0, W, 1'b0);
    ss_high();
`ifdef DARKROOM_SPI_RX_ECHO_EN
    check_val("echo_loopback", 64'(miso_cap), 64'h12345678);
`else
    check_val("miso_tied_low2", 64'(miso_cap), 64'd0);
`endif
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/darkroom_spi_rx.md
Name: darkroom_spi_rx

Overview:
- SPI slave receiver at the far end of the darkroom sensor link.
- Accepts MOSI/SCK/SS_N frames driven by the darkroom SPI master (mode 0, MSB first) and deserialises them into WORD_WIDTH-bit words.
- Buffers the words in a FIFO and presents them on a valid/ready stream to the host-side consumer, e.g. the HPS bridge or a logging block.
- Sits on the receiving FPGA or test fixture, clocked by the local system clock; SCK is oversampled, not used as a clock.

Parameters:
- WORD_WIDTH, 32, bits per received word; must be 8..64.
- FIFO_DEPTH, 16, word entries; power of two, 2..256.
- CNT_WIDTH, 8, width of the partial-word error counter.

Ports:
- clk  in  1  system clock; SCK must be at most clk/8.
- reset_n  in  1  asynchronous active-low reset.
- spi_sck_i  in  1  SPI clock from the master; asynchronous.
- spi_mosi_i  in  1  SPI data from the master; asynchronous.
- spi_ss_n_i  in  1  slave select, active low; asynchronous.
- spi_miso_o  out  1  echo data (optional feature); 0 when the feature is disabled.
- rx_data_o  out  WORD_WIDTH  head-of-FIFO word.
- rx_first_o  out  1  head word was the first word after an SS_N fall.
- rx_valid_o  out  1  FIFO not empty.
- rx_ready_i  in  1  consumer accepts the head word.
- fifo_level_o  out  log2(FIFO_DEPTH)+1  current occupancy.
- overflow_o  out  1  sticky: a word was dropped because the FIFO was full.
- frag_cnt_o  out  CNT_WIDTH  count of partial words discarded; saturating.
- clear_i  in  1  synchronous pulse: clears overflow_o and frag_cnt_o.

Behaviour:
- Reset is asynchronous and active-low. In reset:
  - All outputs are 0.
  - FIFO is emptied.
  - Shift register and bit counter are cleared.
  - State is IDLE.
  - Synchronisers load SCK=0, SS_N=1, MOSI=0.
- Input synchronisation:
  - SCK, SS_N and MOSI each pass through a 2-FF synchroniser.
  - One further register stage on each provides edge detection.
  - SCK rise: synced value is 1 and previous value is 0.
  - SS_N fall and SS_N rise are detected the same way.
- State machine, IDLE:
  - On SS_N fall: go to SHIFT, bit_cnt=0, set first_pending=1.
- State machine, SHIFT:
  - On each SCK rise, with SS_N low: shift = {shift[WORD_WIDTH-2:0], mosi_sync}, then bit_cnt++.
  - When bit_cnt reaches WORD_WIDTH-1 and an SCK rise occurs, the completed word (including this bit) is pushed next cycle with first flag = first_pending.
  - After the push: first_pending=0, bit_cnt=0, remain in SHIFT.
  - On SS_N rise with bit_cnt != 0: discard the partial word and increment frag_cnt_o, saturating at all-ones. Go to IDLE.
  - On SS_N rise with bit_cnt == 0: go to IDLE; no error.
  - SCK rise and SS_N rise in the same cycle: SS_N rise wins and the bit is ignored.
- Latency: rx_valid_o rises at most 5 clk cycles after the raw SCK edge carrying the last bit, when the FIFO was empty.
- FIFO:
  - Circular buffer of FIFO_DEPTH entries; each entry holds {first, data}.
  - Read pointer and write pointer wrap modulo FIFO_DEPTH.
  - Show-ahead: rx_data_o and rx_first_o are valid whenever rx_valid_o = 1.
  - Pop occurs when rx_valid_o && rx_ready_i.
  - Push while full: the word is dropped, overflow_o is set to 1, and existing contents are untouched.
  - Simultaneous push and pop when full: both succeed, no overflow, level unchanged.
  - Simultaneous push and pop when empty: the word is written; rx_valid_o rises next cycle; no pop.
  - fifo_level_o is the registered occupancy, 0..FIFO_DEPTH.
- clear_i:
  - clear_i and an increment of frag_cnt_o in the same cycle: result is 1.
  - clear_i and an overflow in the same cycle: overflow_o is 1.
  - FIFO contents are unaffected.
- Mid-frame reset: the partial word is lost and frag_cnt_o stays 0. After reset, state is IDLE until the next SS_N fall; SCK edges while in IDLE are ignored.

Optional Feature:
- Macro: DARKROOM_SPI_RX_ECHO_EN.
- Defined:
  - spi_miso_o shifts out the previously completed word, MSB first.
  - Each bit is updated on the synchronised SCK fall while SS_N is low.
  - The echo register loads on each word completion.
  - Before the first completed word since reset, echo = 0.
  - spi_miso_o = 0 while SS_N is high.
  - Lets the master verify the link by loopback with one word of lag.
- Not defined:
  - spi_miso_o is tied to 0.
  - No echo register is instantiated.

Test Plan:
- Single word: SS_N low, 32 bits of 0xDEADBEEF at clk/8, SS_N high -> one entry with rx_data_o=0xDEADBEEF, rx_first_o=1, rx_valid_o high within 5 clk of the last SCK rise, frag_cnt_o=0.
- Multi-word frame: 3 words 0x00000001, 0x80000000, 0xA5A5A5A5 in one SS_N low period -> popped in order with rx_first_o=1,0,0; fifo_level_o steps 1,2,3 with rx_ready_i=0.
- Fragment: 20 bits then SS_N rise -> no FIFO push, frag_cnt_o=1. The next full frame is received correctly with rx_first_o=1.
- Overflow: rx_ready_i=0, send 17 words with FIFO_DEPTH=16 -> fifo_level_o=16, overflow_o=1, first 16 words intact, word 17 absent. A clear_i pulse -> overflow_o=0.
- Full with simultaneous pop: FIFO full, rx_ready_i=1 in the same cycle a word completes -> level stays 16, overflow_o stays 0, new word appears at the tail.
- Reset mid-word: assert reset_n=0 after 10 bits, release, send one full word 0x12345678 -> exactly one entry equal to 0x12345678, frag_cnt_o=0. With DARKROOM_SPI_RX_ECHO_EN: the second frame's MISO bits read back 0x12345678.
